// File: rtl/char_writer_pkg.sv
// Shared geometry, control codes and writer state encoding for the character buffer.
// The VGA text renderer imports the same COLS/ROWS so both sides agree on the layout.
package char_writer_pkg;

   localparam int COLS   = 80;
   localparam int ROWS   = 24;
   localparam int CELLS  = ROWS * COLS;
   localparam int ADDR_W = 11;
   localparam int ROW_W  = 5;
   localparam int COL_W  = 7;

   localparam logic [7:0] BLANK = 8'h20;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_BS = 8'h08;

   typedef enum logic [1:0] {
      ST_INIT_CLR = 2'd0,
      ST_IDLE     = 2'd1,
      ST_LINE_CLR = 2'd2
   } wr_state_t;

   function automatic logic is_printable(input logic [7:0] c);
      return (c >= 8'h20) && (c <= 8'h7E);
   endfunction

endpackage

// File: rtl/char_writer_if.sv
// Byte stream (valid/ready) plus character buffer write port of the char writer.
interface char_writer_if;
   import char_writer_pkg::*;

   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic [ADDR_W-1:0] buf_addr;
   logic [7:0]        buf_din;
   logic              buf_wen;

   modport master (
      output in_data, in_valid,
      input  in_ready, buf_addr, buf_din, buf_wen
   );

   modport slave (
      input  in_data, in_valid,
      output in_ready, buf_addr, buf_din, buf_wen
   );

endinterface

// File: rtl/char_addr_calc.sv
// Screen row + column to char buffer address, rotating the row by first_row mod ROWS.
module char_addr_calc
   import char_writer_pkg::*;
(
   input  logic [ROW_W-1:0]  i_first_row,
   input  logic [ROW_W-1:0]  i_row,
   input  logic [COL_W-1:0]  i_col,
   output logic [ADDR_W-1:0] o_addr
);

   logic [ROW_W:0]    w_sum;
   logic [ROW_W-1:0]  w_br;
   logic [ADDR_W-1:0] w_br_ext;
   logic [ADDR_W-1:0] w_col_ext;

   // Both operands are < ROWS, so a single conditional subtract is a full mod.
   assign w_sum     = {1'b0, i_first_row} + {1'b0, i_row};
   assign w_br      = (w_sum >= (ROW_W+1)'(ROWS)) ? ROW_W'(w_sum - (ROW_W+1)'(ROWS))
                                                  : w_sum[ROW_W-1:0];
   assign w_br_ext  = {{(ADDR_W-ROW_W){1'b0}}, w_br};
   assign w_col_ext = {{(ADDR_W-COL_W){1'b0}}, i_col};

   // br*80 as br*64 + br*16
   assign o_addr = (w_br_ext << 6) + (w_br_ext << 4) + w_col_ext;

endmodule

// File: rtl/char_writer.sv
// Write side of the text character buffer: byte stream in, cursor tracking, scroll by
// rotating first_row and blanking the newly exposed bottom line.
//
// state       | meaning
// ------------+---------------------------------------------------------------
// ST_INIT_CLR | blank the whole buffer, one cell per cycle, input stalled
// ST_IDLE     | accept bytes; glyph write / CR / LF / BS handled at acceptance
// ST_LINE_CLR | blank the buffer row that just scrolled to the bottom
module char_writer
   import char_writer_pkg::*;
(
   input  logic              i_pclk,
   input  logic              i_clr,
   char_writer_if.slave      s_bus,
   output logic [ROW_W-1:0]  o_first_row,
   output logic [ROW_W-1:0]  o_cursor_row,
   output logic [COL_W-1:0]  o_cursor_col
);

   wr_state_t         r_state,      w_state_nxt;
   logic [ADDR_W-1:0] r_clr_cnt,    w_clr_cnt_nxt;
   logic              r_buf_wen,    w_buf_wen_nxt;
   logic [ADDR_W-1:0] r_buf_addr,   w_buf_addr_nxt;
   logic [7:0]        r_buf_din,    w_buf_din_nxt;
   logic [ROW_W-1:0]  r_first_row,  w_first_row_nxt;
   logic [ROW_W-1:0]  r_cursor_row, w_cursor_row_nxt;
   logic [COL_W-1:0]  r_cursor_col, w_cursor_col_nxt;

   logic [COL_W-1:0]  w_calc_col;
   logic [ADDR_W-1:0] w_addr;

   // During a line clear cursor_row is ROWS-1, so first_row+cursor_row lands on the
   // old first_row, which is exactly the row being blanked.
   assign w_calc_col = (r_state == ST_LINE_CLR) ? r_clr_cnt[COL_W-1:0] : r_cursor_col;

   char_addr_calc u_addr_calc (
      .i_first_row (r_first_row),
      .i_row       (r_cursor_row),
      .i_col       (w_calc_col),
      .o_addr      (w_addr)
   );

   always_ff @(posedge i_pclk or posedge i_clr) begin
      if (i_clr) begin
         r_state      <= ST_INIT_CLR;
         r_clr_cnt    <= '0;
         r_buf_wen    <= 1'b0;
         r_buf_addr   <= '0;
         r_buf_din    <= BLANK;
         r_first_row  <= '0;
         r_cursor_row <= '0;
         r_cursor_col <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_clr_cnt    <= w_clr_cnt_nxt;
         r_buf_wen    <= w_buf_wen_nxt;
         r_buf_addr   <= w_buf_addr_nxt;
         r_buf_din    <= w_buf_din_nxt;
         r_first_row  <= w_first_row_nxt;
         r_cursor_row <= w_cursor_row_nxt;
         r_cursor_col <= w_cursor_col_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_clr_cnt_nxt    = r_clr_cnt;
      w_buf_wen_nxt    = 1'b0;
      w_buf_addr_nxt   = r_buf_addr;
      w_buf_din_nxt    = r_buf_din;
      w_first_row_nxt  = r_first_row;
      w_cursor_row_nxt = r_cursor_row;
      w_cursor_col_nxt = r_cursor_col;

      case (r_state)
         ST_INIT_CLR: begin
            w_buf_wen_nxt  = 1'b1;
            w_buf_addr_nxt = r_clr_cnt;
            w_buf_din_nxt  = BLANK;
            if (r_clr_cnt == ADDR_W'(CELLS-1)) begin
               w_clr_cnt_nxt = '0;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end

         ST_IDLE: begin
            if (s_bus.in_valid) begin
               if (is_printable(s_bus.in_data)) begin
                  w_buf_wen_nxt  = 1'b1;
                  w_buf_addr_nxt = w_addr;
                  w_buf_din_nxt  = s_bus.in_data;
                  if (r_cursor_col < COL_W'(COLS-1))
                     w_cursor_col_nxt = r_cursor_col + 1'b1;
               end else if (s_bus.in_data == CH_CR) begin
                  w_cursor_col_nxt = '0;
               end else if (s_bus.in_data == CH_BS) begin
                  if (r_cursor_col != '0)
                     w_cursor_col_nxt = r_cursor_col - 1'b1;
               end else if (s_bus.in_data == CH_LF) begin
                  if (r_cursor_row < ROW_W'(ROWS-1)) begin
                     w_cursor_row_nxt = r_cursor_row + 1'b1;
                  end else begin
                     w_first_row_nxt = (r_first_row == ROW_W'(ROWS-1)) ? '0
                                                                       : r_first_row + 1'b1;
                     w_clr_cnt_nxt   = '0;
                     w_state_nxt     = ST_LINE_CLR;
                  end
               end
            end
         end

         ST_LINE_CLR: begin
            w_buf_wen_nxt  = 1'b1;
            w_buf_addr_nxt = w_addr;
            w_buf_din_nxt  = BLANK;
            if (r_clr_cnt == ADDR_W'(COLS-1)) begin
               w_clr_cnt_nxt = '0;
               w_state_nxt   = ST_IDLE;
            end else begin
               w_clr_cnt_nxt = r_clr_cnt + 1'b1;
            end
         end

         default: begin
            w_state_nxt   = ST_INIT_CLR;
            w_clr_cnt_nxt = '0;
         end
      endcase
   end

   assign s_bus.in_ready = (r_state == ST_IDLE);
   assign s_bus.buf_wen  = r_buf_wen;
   assign s_bus.buf_addr = r_buf_addr;
   assign s_bus.buf_din  = r_buf_din;
   assign o_first_row    = r_first_row;
   assign o_cursor_row   = r_cursor_row;
   assign o_cursor_col   = r_cursor_col;

endmodule

// File: tb/tb_char_writer.sv
// Scoreboard bench for char_writer: stimulus queues expected buffer writes, a monitor
// pops and compares each buf_wen pulse; cursor/scroll state is checked directly.
module tb_char_writer;
   import char_writer_pkg::*;

   typedef struct {
      logic [10:0] addr;
      logic [7:0]  din;
   } wr_t;

   logic       clk;
   logic       clr;
   logic [4:0] first_row;
   logic [4:0] cursor_row;
   logic [6:0] cursor_col;

   int  checks   = 0;
   int  failures = 0;
   wr_t exp_q[$];

   char_writer_if bi ();

   char_writer dut (
      .i_pclk       (clk),
      .i_clr        (clr),
      .s_bus        (bi.slave),
      .o_first_row  (first_row),
      .o_cursor_row (cursor_row),
      .o_cursor_col (cursor_col)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int addr, input logic [7:0] din);
      wr_t w;
      w.addr = 11'(addr);
      w.din  = din;
      exp_q.push_back(w);
   endtask

   task automatic send(input logic [7:0] b);
      int n = 0;
      @(negedge clk);
      bi.in_data  = b;
      bi.in_valid = 1'b1;
      while (!bi.in_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!bi.in_ready) begin
         failures++;
         $display("FAIL send_ready: got in_ready=0 after %0d cycles expected 1", n);
      end
      @(posedge clk);
      #1 bi.in_valid = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      int n = 0;
      while (!bi.in_ready && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(bi.in_ready), 32'd1);
   endtask

   // Monitor: every write must match the head of the expected queue.
   always @(negedge clk) begin
      if (!clr && bi.buf_wen) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_write: got addr=%0d din=%0h expected no write",
                     bi.buf_addr, bi.buf_din);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bi.buf_addr !== e.addr || bi.buf_din !== e.din) begin
               failures++;
               $display("FAIL write: got addr=%0d din=%0h expected addr=%0d din=%0h",
                        bi.buf_addr, bi.buf_din, e.addr, e.din);
            end
         end
      end
   end

   initial begin
      int fr;
      int lo;

      clr         = 1'b1;
      bi.in_valid = 1'b0;
      bi.in_data  = 8'h00;
      #12;
      check("rst_ready",     32'(bi.in_ready), 32'd0);
      check("rst_wen",       32'(bi.buf_wen),  32'd0);
      check("rst_addr",      32'(bi.buf_addr), 32'd0);
      check("rst_din",       32'(bi.buf_din),  32'h20);
      check("rst_first_row", 32'(first_row),   32'd0);
      check("rst_cursor",    {cursor_row, cursor_col}, 32'd0);

      // 1: power-up clear
      for (int i = 0; i < 1920; i++) push(i, 8'h20);
      @(negedge clk);
      clr = 1'b0;
      wait_ready("init_ready");
      @(negedge clk);
      check("init_writes_done", 32'(exp_q.size()), 32'd0);

      // 2: two glyphs
      push(0, 8'h41);
      push(1, 8'h42);
      send(8'h41);
      send(8'h42);
      @(negedge clk);
      check("ab_col", 32'(cursor_col), 32'd2);

      // 3: run off the right edge, column pins at 79
      send(CH_CR);
      check("cr_col", 32'(cursor_col), 32'd0);
      for (int k = 0; k < 85; k++) begin
         push((k < 79) ? k : 79, 8'h58);
         send(8'h58);
      end
      check("x_col", 32'(cursor_col), 32'd79);

      // 4: CR LF glyph then backspace into column 0
      send(CH_CR);
      send(CH_LF);
      push(80, 8'h5A);
      send(8'h5A);
      check("z_row", 32'(cursor_row), 32'd1);
      check("z_col", 32'(cursor_col), 32'd1);
      send(CH_BS);
      send(CH_BS);
      check("bs_col", 32'(cursor_col), 32'd0);

      // 5: walk to the bottom row, then scroll
      for (int k = 0; k < 22; k++) send(CH_LF);
      check("bottom_row", 32'(cursor_row), 32'd23);
      check("bottom_first", 32'(first_row), 32'd0);
      for (int c = 0; c < 80; c++) push(c, 8'h20);
      send(CH_LF);
      lo = 0;
      @(negedge clk);
      while (!bi.in_ready && lo < 200) begin
         lo++;
         @(negedge clk);
      end
      check("scroll_stall_cycles", 32'(lo), 32'd80);
      check("scroll_first", 32'(first_row), 32'd1);
      check("scroll_row", 32'(cursor_row), 32'd23);
      push(0, 8'h51);
      send(8'h51);
      check("q_col", 32'(cursor_col), 32'd1);

      // first_row wraps 23 -> 0 after 23 more scrolls
      fr = 1;
      for (int k = 0; k < 23; k++) begin
         for (int c = 0; c < 80; c++) push(fr * 80 + c, 8'h20);
         send(CH_LF);
         fr = (fr + 1) % 24;
      end
      wait_ready("wrap_ready");
      check("wrap_first", 32'(first_row), 32'd0);

      // control byte outside the decoded set is swallowed
      send(8'h07);
      check("ignored_col", 32'(cursor_col), 32'd1);
      push(23 * 80 + 1, 8'h4D);
      send(8'h4D);
      check("m_col", 32'(cursor_col), 32'd2);

      // 6: reset in the middle of a line clear with a byte pending
      for (int c = 0; c < 80; c++) push(c, 8'h20);
      send(CH_LF);
      repeat (10) @(negedge clk);
      #1;
      bi.in_data  = 8'h4B;
      bi.in_valid = 1'b1;
      clr         = 1'b1;
      #1;
      check("clr_wen",   32'(bi.buf_wen),  32'd0);
      check("clr_addr",  32'(bi.buf_addr), 32'd0);
      check("clr_din",   32'(bi.buf_din),  32'h20);
      check("clr_ready", 32'(bi.in_ready), 32'd0);
      check("clr_first", 32'(first_row),   32'd0);
      check("clr_cursor", {cursor_row, cursor_col}, 32'd0);
      exp_q.delete();
      for (int i = 0; i < 1920; i++) push(i, 8'h20);
      push(0, 8'h4B);
      @(negedge clk);
      clr = 1'b0;
      wait_ready("reinit_ready");
      @(posedge clk);
      #1 bi.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check("k_col", 32'(cursor_col), 32'd1);
      check("final_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
